// File: rtl/bcd_stopwatch.sv
// SS.cc BCD stopwatch with start/stop and clear buttons; optional lap hold via BCD_STOPWATCH_LAP_EN.
// Latency: a button press acts 2 clocks after it is sampled, and all outputs are registered.
// Backpressure: none; the buttons are level inputs and the digits are free-running registers.
module bcd_stopwatch #(
  parameter int TICK_DIV = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_clr,
`ifdef BCD_STOPWATCH_LAP_EN
  input  logic       btn_lap,
`endif
  output logic [3:0] val3,
  output logic [3:0] val2,
  output logic [3:0] val1,
  output logic [3:0] val0,
  output logic       running,
  output logic       ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_next;
  logic [2:0]    ss_sh, clr_sh;
  logic          ss_ev, clr_ev;
  logic [PW-1:0] presc;
  logic          tick, do_clr, carry_out;
  logic [15:0]   cnt, cnt_inc, cnt_next;

  // Bits [1:0] synchronize the button and bit [2] delays it for edge detection.
  assign ss_ev  = ss_sh[1] & ~ss_sh[2];
  assign clr_ev = clr_sh[1] & ~clr_sh[2];
  assign tick   = (state == RUN) && (presc == PMAX);

  always_comb begin
    state_next = state;
    do_clr     = 1'b0;
    case (state)
      IDLE: begin
        if (clr_ev)     do_clr = 1'b1;
        else if (ss_ev) state_next = RUN;
      end
      RUN: begin
        if (ss_ev) state_next = PAUSE;
      end
      PAUSE: begin
        if (clr_ev) begin
          state_next = IDLE;
          do_clr     = 1'b1;
        end else if (ss_ev) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    logic c;
    cnt_inc = '0;
    c       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c && (cnt[4*i +: 4] == 4'd9)) begin
        cnt_inc[4*i +: 4] = 4'd0;
      end else begin
        cnt_inc[4*i +: 4] = cnt[4*i +: 4] + {3'b000, c};
        c = 1'b0;
      end
    end
    carry_out = c;
  end

  always_comb begin
    cnt_next = cnt;
    if (do_clr)    cnt_next = '0;
    else if (tick) cnt_next = cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ss_sh   <= '0;
      clr_sh  <= '0;
      presc   <= '0;
      cnt     <= '0;
      running <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_next;
      ss_sh   <= {ss_sh[1:0], btn_ss};
      clr_sh  <= {clr_sh[1:0], btn_clr};
      // A paused partial interval is thrown away.
      if (state != RUN || tick) presc <= '0;
      else                      presc <= presc + 1'b1;
      cnt     <= cnt_next;
      running <= (state_next == RUN);
      if (do_clr)                 ovf <= 1'b0;
      else if (tick && carry_out) ovf <= 1'b1;
    end
  end

`ifdef BCD_STOPWATCH_LAP_EN
  logic [2:0]  lap_sh;
  logic        lap_ev, lap_hold, hold_next;
  logic [15:0] disp;

  assign lap_ev = lap_sh[1] & ~lap_sh[2];

  always_comb begin
    hold_next = lap_hold;
    if (state_next != RUN)        hold_next = 1'b0;
    else if (state == RUN && lap_ev) hold_next = ~lap_hold;
  end

  // While held, disp keeps the value shown on the capture edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_sh   <= '0;
      lap_hold <= 1'b0;
      disp     <= '0;
    end else begin
      lap_sh   <= {lap_sh[1:0], btn_lap};
      lap_hold <= hold_next;
      if (!hold_next) disp <= cnt_next;
    end
  end

  assign {val3, val2, val1, val0} = disp;
`else
  assign {val3, val2, val1, val0} = cnt;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Randomized and directed checks of bcd_stopwatch against a time-in-hundredths model.
module tb_bcd_stopwatch;

  localparam int TICK_DIV = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_ss = 1'b1;
  logic       btn_clr = 1'b1;
  logic [3:0] val3, val2, val1, val0;
  logic       running, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: elapsed time as an integer, state, cycles spent in the current tick interval.
  int   m_time = 0;
  int   m_state = S_IDLE;
  int   m_rc = 0;
  bit   m_ovf = 1'b0;
  bit [2:0] ss_h = '0, clr_h = '0;

  bcd_stopwatch #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .val3(val3), .val2(val2), .val1(val1), .val0(val0),
    .running(running), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] model_vec();
    return {4'(m_time / 1000), 4'((m_time / 100) % 10), 4'((m_time / 10) % 10),
            4'(m_time % 10), (m_state == S_RUN), m_ovf};
  endfunction

  // A press counts at edge n when the button was sampled high at n-2 and low at n-3.
  initial begin
    bit ss_ev, clr_ev;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_time = 0; m_state = S_IDLE; m_rc = 0; m_ovf = 1'b0;
        ss_h = '0; clr_h = '0;
      end else begin
        ss_ev  = ss_h[1] && !ss_h[2];
        clr_ev = clr_h[1] && !clr_h[2];
        ss_h   = {ss_h[1:0], btn_ss};
        clr_h  = {clr_h[1:0], btn_clr};
        if (m_state == S_RUN) begin
          m_rc++;
          if (m_rc == TICK_DIV) begin
            m_rc = 0;
            m_time = (m_time + 1) % 10000;
            if (m_time == 0) m_ovf = 1'b1;
          end
        end
        case (m_state)
          S_IDLE: begin
            if (clr_ev) m_ovf = 1'b0;
            else if (ss_ev) begin m_state = S_RUN; m_rc = 0; end
          end
          S_RUN: if (ss_ev) m_state = S_PAUSE;
          default: begin
            if (clr_ev) begin m_state = S_IDLE; m_time = 0; m_ovf = 1'b0; end
            else if (ss_ev) begin m_state = S_RUN; m_rc = 0; end
          end
        endcase
      end
    end
  end

  initial begin
    logic [17:0] got, exp;
    forever begin
      @(negedge clk);
      got = {val3, val2, val1, val0, running, ovf};
      exp = model_vec();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, got, exp);
      end
    end
  end

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [17:0] dut_vec();
    return {val3, val2, val1, val0, running, ovf};
  endfunction

  task automatic wait_time(input int target, input string name);
    int n = 0;
    while (m_time != target && n < 50000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50000) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout got=%0d expected=%0d", name, m_time, target);
    end
  endtask

  task automatic press(input bit ss, input bit clr);
    btn_ss = ss; btn_clr = clr;
    @(negedge clk);
    btn_ss = 1'b0; btn_clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset with both buttons held, then release reset while still held.
    repeat (2) @(negedge clk);
    check("reset_outputs", dut_vec(), 18'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("held_buttons_after_reset", dut_vec(), 18'h0);
    btn_ss = 1'b0; btn_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Start: running rises at edge k+2, first increment TICK_DIV edges later.
    btn_ss = 1'b1;
    @(negedge clk);
    btn_ss = 1'b0;
    @(negedge clk);
    check("running_k1", {17'h0, running}, 18'h0);
    @(negedge clk);
    check("running_k2", dut_vec(), 18'h2);
    repeat (3) @(negedge clk);
    check("before_first_tick", dut_vec(), 18'h2);
    @(negedge clk);
    check("first_tick", dut_vec(), {16'h0001, 2'b10});
    repeat (156) @(negedge clk);
    check("forty_ticks", dut_vec(), {16'h0040, 2'b10});

    // Carry chain and wrap.
    wait_time(999, "reach_0999");
    check("at_0999", dut_vec(), {16'h0999, 2'b10});
    repeat (TICK_DIV) @(negedge clk);
    check("carry_1000", dut_vec(), {16'h1000, 2'b10});
    wait_time(9999, "reach_9999");
    check("at_9999", dut_vec(), {16'h9999, 2'b10});
    repeat (TICK_DIV) @(negedge clk);
    check("wrap_ovf", dut_vec(), {16'h0000, 2'b11});
    press(1'b1, 1'b0);
    check("pause_running", {17'h0, running}, 18'h0);
    press(1'b0, 1'b1);
    check("clear_after_wrap", dut_vec(), 18'h0);

    // Priority: RUN takes ss, PAUSE takes clr, clr alone in RUN does nothing.
    press(1'b1, 1'b0);
    repeat (50) @(negedge clk);
    press(1'b1, 1'b1);
    check("run_both_pauses", {17'h0, running}, 18'h0);
    repeat (20) @(negedge clk);
    check("paused_hold", {val3, val2, val1, val0, running, ovf}, {16'h0013, 2'b00});
    press(1'b1, 1'b1);
    check("pause_both_clears", dut_vec(), 18'h0);
    press(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    press(1'b0, 1'b1);
    check("clr_ignored_in_run", {17'h0, running}, 18'h1);

    // Random buttons and occasional reset.
    for (int i = 0; i < 4000; i++) begin
      btn_ss  = ($urandom_range(0, 29) == 0);
      btn_clr = ($urandom_range(0, 39) == 0);
      rst_n   = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
